// File: rtl/control_selector_frecuencias_pkg.sv
// Shared definitions for the frequency selector controller and its mux:
// select width, saturation limits, FSM encoding and the saturating step.
package control_selector_frecuencias_pkg;

    localparam int SELECTOR_W = 3;
    localparam logic [SELECTOR_W-1:0] SEL_MAX = 3'b111;
    localparam logic [SELECTOR_W-1:0] SEL_MIN = '0;
    localparam logic [SELECTOR_W-1:0] SEL_UNO = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESPERA = 2'd1,
        APLICA = 2'd2
    } estado_t;

    // One saturating step of the target; simultaneous up/down requests cancel.
    function automatic logic [SELECTOR_W-1:0] paso_saturado(
        input logic [SELECTOR_W-1:0] actual,
        input logic                  sube,
        input logic                  baja
    );
        logic [SELECTOR_W-1:0] resultado;
        resultado = actual;
        if (sube && !baja && actual != SEL_MAX) begin
            resultado = actual + SEL_UNO;
        end else if (baja && !sube && actual != SEL_MIN) begin
            resultado = actual - SEL_UNO;
        end
        return resultado;
    endfunction

endpackage

// File: rtl/control_selector_frecuencias_antirrebote.sv
// Button conditioner: 2-flop synchronizer, stable-time debounce counter and a
// one-cycle pulse on each 0->1 change of the debounced level.
module antirrebote #(
    parameter int DEB_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic entrada,
    output logic flanco
);

    localparam logic [15:0] CNT_FIN = 16'(DEB_CYCLES - 1);

    logic [1:0]  sync_q;
    logic [15:0] cnt_q;
    logic        nivel_q;

    // Synchronize, time how long the input disagrees with the level, flip the level once stable.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            flanco  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
            // shift register and counter behave as hardware regardless of statement order.
            sync_q <= {sync_q[0], entrada};
            flanco <= 1'b0;
            if (sync_q[1] == nivel_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_FIN) begin
                cnt_q   <= '0;
                nivel_q <= sync_q[1];
                flanco  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: rtl/control_selector_frecuencias.sv
// Frequency selector controller: debounced up/down buttons move a saturating
// target; the target is committed to Selector only on an Fsw falling edge or
// after a timeout, so the mux never switches mid-period.
module control_selector_frecuencias
    import control_selector_frecuencias_pkg::*;
#(
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Btn_Up,
    input  logic                  Btn_Down,
    input  logic                  Fsw,
    output logic [SELECTOR_W-1:0] Selector,
    output logic                  Pendiente,
    output logic                  Cambio
);

    localparam logic [15:0] TIMEOUT_FIN = 16'(TIMEOUT_CYCLES - 1);

    logic                  up_edge;
    logic                  down_edge;
    logic [2:0]            fsw_q;
    logic                  fsw_bajada;

    estado_t               estado_q, estado_d;
    logic [SELECTOR_W-1:0] target_q, target_d;
    logic [15:0]           timeout_q, timeout_d;
    logic [SELECTOR_W-1:0] selector_d;
    logic                  pendiente_d;
    logic                  cambio_d;

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote_up (
        .Clk    (Clk),
        .Reset  (Reset),
        .entrada(Btn_Up),
        .flanco (up_edge)
    );

    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote_down (
        .Clk    (Clk),
        .Reset  (Reset),
        .entrada(Btn_Down),
        .flanco (down_edge)
    );

    // Fsw synchronizer plus one history stage for falling-edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fsw_q <= '0;
        end else begin
            fsw_q <= {fsw_q[1:0], Fsw};
        end
    end

    assign fsw_bajada = fsw_q[2] & ~fsw_q[1];

    // Next-state and output decode; the target tracks requests in every state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        estado_d    = estado_q;
        target_d    = paso_saturado(target_q, up_edge, down_edge);
        timeout_d   = timeout_q;
        selector_d  = Selector;
        pendiente_d = Pendiente;
        cambio_d    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (target_d != Selector) begin
                    estado_d    = ESPERA;
                    timeout_d   = '0;
                    pendiente_d = 1'b1;
                end
            end
            ESPERA: begin
                if (target_d == Selector) begin
                    estado_d    = IDLE;
                    pendiente_d = 1'b0;
                end else if (fsw_bajada || timeout_q == TIMEOUT_FIN) begin
                    estado_d = APLICA;
                end else begin
                    timeout_d = timeout_q + 16'd1;
                end
            end
            APLICA: begin
                selector_d  = target_q;
                cambio_d    = 1'b1;
                pendiente_d = 1'b0;
                estado_d    = IDLE;
            end
            default: begin
                estado_d    = IDLE;
                pendiente_d = 1'b0;
            end
        endcase
    end

    // State, target, timeout and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            estado_q  <= IDLE;
            target_q  <= SEL_MIN;
            timeout_q <= '0;
            Selector  <= SEL_MIN;
            Pendiente <= 1'b0;
            Cambio    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
            Selector  <= selector_d;
            Pendiente <= pendiente_d;
            Cambio    <= cambio_d;
        end
    end

endmodule

// File: doc/control_selector_frecuencias.md
CONTROL_SELECTOR_FRECUENCIAS -- requirements
Module: control_selector_frecuencias

Interface
REQ-001 Parameter DEB_CYCLES, default 16, debounce stable-time in Clk cycles (1..65535).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum wait for an Fsw falling edge before a forced commit (1..65535).
REQ-003 Port Clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 Port Reset, input, 1, asynchronous active-low reset: asserts immediately when low, releases on the Clk edge after it goes high.
REQ-005 Port Btn_Up, input, 1, raw asynchronous request to step the frequency selection up.
REQ-006 Port Btn_Down, input, 1, raw asynchronous request to step the frequency selection down.
REQ-007 Port Fsw, input, 1, currently switched frequency returned from the frequency mux; asynchronous to Clk.
REQ-008 Port Selector, output, 3, registered select value driving the frequency mux.
REQ-009 Port Pendiente, output, 1, high while a requested selection is waiting to be committed.
REQ-010 Port Cambio, output, 1, one-cycle pulse in the cycle Selector takes a new value.

Function
REQ-011 Btn_Up, Btn_Down and Fsw SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Each synchronized button SHALL be debounced: the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-013 A request SHALL be generated only on a 0->1 edge of a debounced button: one press gives one step, and holding the button gives no repeat.
REQ-014 Up and down edges in the same cycle SHALL cancel, with no change to the target.
REQ-015 The internal 3-bit target SHALL saturate at 3'b111 going up and at 3'b000 going down, with no wrap-around.
REQ-016 The FSM SHALL have the states IDLE, ESPERA and APLICA.
REQ-017 In IDLE, a request whose saturated target differs from Selector SHALL move the FSM to ESPERA, clear the timeout counter and raise Pendiente; a request that leaves the target equal to Selector SHALL be ignored.
REQ-018 In ESPERA, further requests SHALL update the target (saturating) without restarting the timeout.
REQ-019 If the target returns to equal Selector while in ESPERA, the FSM SHALL go back to IDLE with no Cambio pulse.
REQ-020 In ESPERA, a falling edge on synchronized Fsw, or the timeout counter reaching TIMEOUT_CYCLES-1, SHALL move the FSM to APLICA.
REQ-021 In APLICA, Selector SHALL load the target, Cambio SHALL pulse for one cycle, Pendiente SHALL drop, and the FSM SHALL return to IDLE on the next cycle.
REQ-022 A request arriving in the APLICA cycle SHALL be retained in the target and re-evaluated in IDLE.
REQ-023 Latency SHALL be as follows: the first Clk edge on which the commit condition is seen in ESPERA enters APLICA, and Selector updates on the following edge, together with the Cambio pulse.
REQ-024 Selector SHALL change only in APLICA, so mux switching stays glitch-free when Fsw toggles.

Reset
REQ-025 While Reset is low: Selector=3'b000, target=3'b000, Pendiente=0, Cambio=0, FSM=IDLE, and all counters, synchronizers and debounced levels are 0.
REQ-026 Reset asserted mid-ESPERA SHALL discard the pending target, and no Cambio pulse SHALL follow its release.

Structure
REQ-027 The FSM state encoding and the width constants SELECTOR_W=3 and SEL_MAX=3'b111 SHALL live in a shared package used by the mux and this controller.
REQ-028 Debouncing SHALL be one sub-module, antirrebote (synchronizer plus counter plus edge output), instantiated twice.

Verification
REQ-029 Reset low, then released with DEB_CYCLES=4 -> Selector=000, Pendiente=0, Cambio=0.
REQ-030 One clean Btn_Up press, then an Fsw falling edge -> Selector=001 one cycle after APLICA is entered, with exactly one Cambio pulse.
REQ-031 Btn_Up bouncing 3 times within 3 cycles, then stable -> exactly one step.
REQ-032 Selector=111 and Btn_Up pressed -> no ESPERA state, no Cambio; Selector=000 and Btn_Down pressed -> likewise.
REQ-033 Fsw held constant with TIMEOUT_CYCLES=8 after a press -> forced commit exactly 8 cycles after ESPERA is entered.
REQ-034 Up then Down during ESPERA -> return to IDLE, Selector unchanged, no Cambio; Reset pulsed low in ESPERA -> Selector=000 and no later Cambio.
